// File: rtl/ram_program_loader_pkg.sv
// Shared types and helpers for the program RAM loader: FSM states,
// default widths and the modular checksum accumulate.
package loader_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Running sum mod 2**DATA_W; the image passes when sum + checksum wraps to zero.
  function automatic logic [DATA_W_DEF-1:0] checksum_add(
    input logic [DATA_W_DEF-1:0] a,
    input logic [DATA_W_DEF-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/ram_program_loader.sv
// Streams a program image into the program RAM from address 0, verifies a
// trailing checksum byte and only then releases the CPU sequencer.
module ram_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              error
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cpu_run;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_sum;

  logic                w_accept;
  logic                w_wr;
  logic                w_clear;
  logic [DATA_W-1:0]   w_sum_total;

  assign w_accept    = r_in_ready & in_valid;
  assign w_sum_total = checksum_add(r_sum, in_data);

  always_comb begin
    w_state_next = r_state;
    w_wr         = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_next = ST_LOAD;
          w_clear      = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_wr = 1'b1;
          // The last RAM slot ends the image even without in_last.
          if (in_last || (r_cnt == '1)) begin
            w_state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_state_next = (w_sum_total == '0) ? ST_DONE : ST_ERROR;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_run  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
    end else begin
      r_state    <= w_state_next;
      // Status outputs are registered decodes of the upcoming state.
      r_in_ready <= (w_state_next == ST_LOAD) || (w_state_next == ST_CSUM);
      r_done     <= (w_state_next == ST_DONE);
      r_cpu_run  <= (w_state_next == ST_DONE);
      r_error    <= (w_state_next == ST_ERROR);
      r_we       <= w_wr;
      if (w_wr) begin
        r_addr  <= r_cnt;
        r_wdata <= in_data;
      end
      if (w_clear) begin
        r_cnt <= '0;
        r_sum <= '0;
      end else if (w_wr) begin
        r_sum <= w_sum_total;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + ADDR_W'(1);
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign cpu_run   = r_cpu_run;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader: drives on the falling edge, samples
// on the falling edge, and logs every RAM write strobe it observes.
module tb_ram_program_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_run;
  logic       done;
  logic       error;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] wa [64];
  logic [7:0] wd [64];
  int         wn = 0;
  int         base;

  ram_program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wn < 64) begin
        wa[wn] = ram_addr;
        wd[wn] = ram_wdata;
      end
      wn = wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run = tests_run + 1;
    assert (obs === exp) else begin
      tests_failed = tests_failed + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, 32'(wa[idx]), 32'(a));
    chk({tag, "_data"}, 32'(wd[idx]), 32'(d));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_image3(input logic [7:0] csum);
    send(8'h0E, 1'b0);
    send(8'h1F, 1'b0);
    send(8'hE0, 1'b1);
    send(csum, 1'b1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("idle");
    chk("idle_no_writes", 32'(wn), 32'd0);

    // Good three-byte image: 0x0E+0x1F+0xE0 = 0x0D, checksum 0xF3.
    base = wn;
    start = 1'b1;
    chk("ready_before_start", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", 32'(in_ready), 32'd1);
    send(8'h0E, 1'b0);
    send(8'h1F, 1'b0);
    send(8'hE0, 1'b1);
    chk("done_before_csum", 32'(done), 32'd0);
    send(8'hF3, 1'b0);
    chk("img1_done", 32'(done), 32'd1);
    chk("img1_cpu_run", 32'(cpu_run), 32'd1);
    chk("img1_error", 32'(error), 32'd0);
    chk("img1_ready_low", 32'(in_ready), 32'd0);
    chk("img1_nwrites", 32'(wn - base), 32'd3);
    chk_wr("img1_w0", base, 4'd0, 8'h0E);
    chk_wr("img1_w1", base + 1, 4'd1, 8'h1F);
    chk_wr("img1_w2", base + 2, 4'd2, 8'hE0);

    // Bytes offered while DONE are not consumed.
    base = wn;
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    chk("done_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_no_writes", 32'(wn - base), 32'd0);
    chk("done_held", 32'(done), 32'd1);

    // Bad checksum, then a correct reload.
    base = wn;
    do_start();
    chk("restart_clears_done", 32'(done), 32'd0);
    chk("restart_clears_run", 32'(cpu_run), 32'd0);
    send_image3(8'hF4);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_cpu_run", 32'(cpu_run), 32'd0);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_nwrites", 32'(wn - base), 32'd3);
    base = wn;
    do_start();
    chk("retry_clears_error", 32'(error), 32'd0);
    send_image3(8'hF3);
    chk("retry_done", 32'(done), 32'd1);
    chk("retry_error", 32'(error), 32'd0);
    chk("retry_nwrites", 32'(wn - base), 32'd3);
    chk_wr("retry_w0", base, 4'd0, 8'h0E);

    // Full 16-byte image without in_last: sum 0x78, checksum 0x88.
    base = wn;
    do_start();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("full_ready_in_csum", 32'(in_ready), 32'd1);
    chk("full_not_done_yet", 32'(done), 32'd0);
    send(8'h88, 1'b0);
    chk("full_done", 32'(done), 32'd1);
    chk("full_nwrites", 32'(wn - base), 32'd16);
    for (int i = 0; i < 16; i++) chk_wr("full_w", base + i, 4'(i), 8'(i));
    @(negedge clk);
    chk("full_no_17th", 32'(wn - base), 32'd16);

    // Stalled stream with a start pulse mid-LOAD: 0x11+0x22+0x33 = 0x66, checksum 0x9A.
    base = wn;
    do_start();
    send(8'h11, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stall_ready_kept", 32'(in_ready), 32'd1);
    send(8'h22, 1'b0);
    @(negedge clk);
    send(8'h33, 1'b1);
    @(negedge clk);
    send(8'h9A, 1'b0);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_nwrites", 32'(wn - base), 32'd3);
    chk_wr("stall_w0", base, 4'd0, 8'h11);
    chk_wr("stall_w1", base + 1, 4'd1, 8'h22);
    chk_wr("stall_w2", base + 2, 4'd2, 8'h33);

    // Asynchronous reset mid-LOAD, while the second write is on the bus.
    do_start();
    send(8'h0E, 1'b0);
    send(8'h1F, 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    base = wn;
    do_start();
    send_image3(8'hF3);
    chk("after_abort_done", 32'(done), 32'd1);
    chk("after_abort_nwrites", 32'(wn - base), 32'd3);
    chk_wr("after_abort_w0", base, 4'd0, 8'h0E);
    chk_wr("after_abort_w2", base + 2, 4'd2, 8'hE0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_program_loader.md
# ram_program_loader

Writes a program image into the 16×8 program RAM before the CPU runs, acting as the writer for the memory that the fetch path (PC → MAR → RAM → IR/A) only reads. It accepts a byte stream over a valid/ready handshake and writes each byte to consecutive RAM addresses from 0. It then checks a trailing checksum byte. Only after a passing check does it release the control sequencer to run.

## Interface
- ADDR_W, 4, RAM address width; image holds at most 2**ADDR_W bytes.
- DATA_W, 8, RAM word / stream byte width.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERROR.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final image byte; sampled only with an accepted byte.
- in_ready  out  1  loader can accept a byte this cycle.
- ram_we  out  1  one-cycle RAM write strobe.
- ram_addr  out  ADDR_W  write address.
- ram_wdata  out  DATA_W  write data.
- cpu_run  out  1  1 = sequencer may fetch; 0 = CPU held.
- done  out  1  image loaded and checksum passed.
- error  out  1  checksum failed.

## Operation
- States: IDLE, LOAD, CSUM, DONE, ERROR.
- IDLE → LOAD on start. Clear the address counter and the 8-bit running sum.
- LOAD:
  - in_ready=1. A byte is accepted on in_valid && in_ready.
  - Each accepted byte is written to the current address, added to the sum mod 2**DATA_W, and the address increments.
  - Go to CSUM after the accepted byte has in_last=1 or address = 2**ADDR_W−1. Whichever comes first ends the image; the address never wraps.
- CSUM:
  - in_ready=1. The next accepted byte is the checksum and is not written to RAM.
  - Pass when (sum + checksum) mod 2**DATA_W = 0; go to DONE, else ERROR.
- DONE: done=1, cpu_run=1. ERROR: error=1, cpu_run=0.
- start in DONE or ERROR clears done, error and cpu_run, then re-enters LOAD with the same initialisation as from IDLE. start in LOAD or CSUM is ignored.
- in_last seen with the checksum byte is ignored.
- in_ready=0 in IDLE, DONE and ERROR. Bytes offered there are not consumed.

## Timing
- Reset values: state IDLE, in_ready 0, ram_we 0, ram_addr 0, ram_wdata 0, cpu_run 0, done 0, error 0.
- in_ready is a registered state decode. It is high from the cycle after start is sampled.
- Write latency: the byte accepted at edge N has ram_we=1 with ram_addr/ram_wdata valid during cycle N→N+1. The RAM captures it at edge N+1. ram_addr and ram_wdata hold their values when ram_we=0.
- Back-to-back transfers sustain one byte per cycle. Stall cycles (in_valid=0) insert no writes.
- done/error/cpu_run assert the cycle after the checksum byte is accepted.
- Reset asserted mid-LOAD or mid-CSUM aborts immediately to reset values. RAM contents already written are left as is.

## Structure
- Package loader_pkg holds: the state enum typedef, ADDR_W/DATA_W defaults, and a checksum function (sum mod 2**DATA_W).
- A single module with no sub-module. The FSM, the address counter and the sum accumulator are small enough to live together.

## Test plan
- Reset at t=0, release, no start → all outputs 0, in_ready 0, no ram_we.
- start; bytes 0x0E, 0x1F, 0xE0 (in_last on 0xE0); checksum 0xF3 → writes addr0=0x0E, addr1=0x1F, addr2=0xE0; done=1, cpu_run=1 one cycle after 0xF3.
- Same image with checksum 0xF4 → three writes, error=1, cpu_run=0. Then start with the correct stream → done=1, error=0.
- 16 bytes 0x00..0x0F with no in_last, then checksum 0x88 → writes to addr 0..15, no 17th write, done=1.
- in_valid toggled 1/0 every cycle during load → exactly one ram_we per accepted byte with sequential addresses; start pulsed mid-LOAD has no effect.
- Reset low after the second byte of the three-byte image → outputs return to reset values asynchronously. A subsequent start plus a full stream writes from addr 0.
